uart_transmitter: RTL and testbench
===================================

# uart_transmitter

UART transmitter for the 8N1 serial link, the transmit-side counterpart of the team's UART receiver. It accepts a byte over a single-cycle valid strobe and serialises it LSB-first onto `o_Serial_Data`: one start bit, 8 data bits, one stop bit, each exactly `FREQUENCY` clocks long. A one-byte holding register lets the next byte be queued during a transmission, so back-to-back frames go out with no idle gap. The block sits between the byte source (test logic or host FSM) and the TX pin.

## Interface
- `FREQUENCY`, 87: clocks per bit (clk / baud; 87 = 10 MHz / 115200). Legal range 2..256.
- `clk`  in  1  system clock; all logic on the rising edge.
- `i_Rst_n`  in  1  asynchronous, active-low reset.
- `i_DV`  in  1  byte valid. Sampled only when `o_Ready`=1.
- `i_Byte`  in  8  byte to send; captured on the edge where `i_DV`&&`o_Ready`.
- `o_Serial_Data`  out  1  serial line, registered, idle high.
- `o_Ready`  out  1  holding register empty; a byte can be accepted.
- `o_Active`  out  1  a frame is on the line (start through stop).
- `o_Done`  out  1  one-cycle pulse at the end of each stop bit.

## Operation
- Holding register: `hold_byte[7:0]` and `hold_full`. `o_Ready` = ~`hold_full`.
- Accept: `i_DV`&&`o_Ready` at an edge → `hold_byte`<=`i_Byte`, `hold_full`<=1. `i_DV` while `o_Ready`=0 is ignored; the byte is dropped and no state changes.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: line=1, `o_Active`=0. If `hold_full`, load the shift register from `hold_byte`, clear `hold_full`, counter<=0, index<=0, line<=0, go to START.
- START: hold line=0. When counter==FREQUENCY-1: counter<=0, line<=shift[0], go to DATA.
- DATA: when counter==FREQUENCY-1: counter<=0. If index<7: index+1, line<=next bit. If index==7: line<=1, go to STOP.
- STOP: hold line=1. When counter==FREQUENCY-1: pulse `o_Done`. If `hold_full`, reload immediately (same action as IDLE) and go to START; otherwise go to IDLE.
- A transfer from holding to shift register and a new accept never occur on the same edge, because `o_Ready` is 0 while `hold_full`. `o_Ready` rises on the cycle after the transfer.
- Counter is `$clog2(FREQUENCY)` bits wide and is never compared beyond FREQUENCY-1.

## Timing
- Reset (asynchronous, takes effect immediately): `o_Serial_Data`=1, `o_Ready`=1, `o_Active`=0, `o_Done`=0, FSM=IDLE, counter=0, index=0, `hold_full`=0. Reset mid-frame aborts the frame: the line goes high at once and the held byte is discarded.
- Latency from idle: byte accepted at edge N; start bit drives the line from edge N+1.
- Frame length: exactly 10·FREQUENCY clocks of line activity.
- `o_Done` is high for the single cycle following the last stop-bit clock.
- Back-to-back: if a byte is held when the stop bit ends, the next start bit begins on that same edge. Line period is 10·FREQUENCY per frame with no idle gap.
- `o_Active` is 1 from the start-bit edge to the end of the stop bit. It stays 1 across back-to-back frames.

## Structure
- Shared package `uart_pkg`:
  - FSM state encodings (IDLE=0, START=1, DATA=2, STOP=3).
  - Default `FREQUENCY`=87.
  - Frame constants: DATA_BITS=8, STOP_BITS=1.
  - The receiver migrates to the same package.
- One natural sub-module: `uart_bit_timer`, a counter 0..FREQUENCY-1 with clear and a terminal-count output. It is reused by the receiver later.

## Test plan
- Reset, then `i_DV` with 0xA5, FREQUENCY=87 → line low for 87 clks; then bits 1,0,1,0,0,1,0,1 at 87 clks each; stop high 87 clks; `o_Done` pulses 870 clks after the start edge; `o_Ready` is back to 1 one clk after acceptance.
- Send 0x00, then 0xFF accepted during the first frame → two contiguous frames totalling 1740 clks with no high gap before the second start bit; two `o_Done` pulses 870 clks apart; `o_Active` is continuously 1.
- Third `i_DV` (0x55) while `o_Ready`=0 → ignored; only the first two bytes appear on the line.
- Assert `i_Rst_n`=0 during data bit 3 → line=1 and `o_Active`=0 immediately, `o_Ready`=1; after release, the line stays high with no spurious frame.
- Loopback into the receiver (same FREQUENCY) with 0x3C and 0x81 → receiver `o_Byte` matches each byte, with one `o_DV` pulse per frame.
- FREQUENCY=2 with 0x01 → 20-clk frame; start bit 2 clks; bit0=1; `o_Done` pulses once.

Source files
------------

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter and receiver: FSM state
// encoding, frame constants, default bit period and the holding-register
// payload type.
// ----------------------------------------------------------------------------
package uart_pkg;

   // Clocks per bit: 10 MHz / 115200 baud.
   localparam int unsigned DEFAULT_FREQUENCY = 87;

   // 8N1 framing.
   localparam int unsigned DATA_BITS = 8;
   localparam int unsigned STOP_BITS = 1;

   // Bit index register width; also counts stop bits.
   localparam int unsigned IDX_W = $clog2(DATA_BITS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   // One-byte holding register between the byte source and the shifter.
   typedef struct packed {
      logic                 full;
      logic [DATA_BITS-1:0] data;
   } uart_hold_t;

   // Bit-period counter width; at least one bit.
   function automatic int unsigned cnt_width(input int unsigned freq);
      return (freq > 1) ? $clog2(freq) : 1;
   endfunction

endpackage : uart_pkg

// File: rtl/uart_bit_timer.sv
// ----------------------------------------------------------------------------
// uart_bit_timer
// Free-running bit-period counter 0..FREQUENCY-1 that wraps to zero at the
// terminal count. Shared by the UART transmitter and receiver.
//
// Ports:
//   clk           in   system clock
//   i_Rst_n       in   asynchronous active-low reset
//   clr_i         in   hold the counter at zero
//   tc_c_o        out  counter is at FREQUENCY-1 (combinational)
// ----------------------------------------------------------------------------
module uart_bit_timer
   import uart_pkg::*;
#(
   parameter int unsigned FREQUENCY = DEFAULT_FREQUENCY
) (
   input  logic clk,
   input  logic i_Rst_n,
   input  logic clr_i,
   output logic tc_c_o
);

   localparam int unsigned      CNT_W    = cnt_width(FREQUENCY);
   localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(FREQUENCY - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tc_c_o = (cnt_q == TERMINAL);

   // Count up, wrap at terminal count so the next bit period starts at zero.
   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (clr_i || tc_c_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule : uart_bit_timer

// File: rtl/uart_transmitter.sv
// ----------------------------------------------------------------------------
// uart_transmitter
// 8N1 UART transmitter. Accepts a byte on a single-cycle valid strobe into a
// one-byte holding register and serialises it LSB-first: start bit, 8 data
// bits, stop bit, each FREQUENCY clocks. A byte held when the stop bit ends
// starts on the same edge, so back-to-back frames have no idle gap.
//
// Ports:
//   clk            in   system clock
//   i_Rst_n        in   asynchronous active-low reset
//   i_DV           in   byte valid, sampled only while o_Ready is high
//   i_Byte[7:0]    in   byte to transmit
//   o_Serial_Data  out  serial line, idle high
//   o_Ready        out  holding register empty
//   o_Active       out  frame on the line (start through stop)
//   o_Done         out  one-cycle pulse after the last stop-bit clock
// ----------------------------------------------------------------------------
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int unsigned FREQUENCY = DEFAULT_FREQUENCY
) (
   input  logic                 clk,
   input  logic                 i_Rst_n,
   input  logic                 i_DV,
   input  logic [DATA_BITS-1:0] i_Byte,
   output logic                 o_Serial_Data,
   output logic                 o_Ready,
   output logic                 o_Active,
   output logic                 o_Done
);

   localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

   uart_state_e          state_q, state_d;
   uart_hold_t           hold_q, hold_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic                 line_q, line_d;
   logic                 active_q, active_d;
   logic                 done_q, done_d;

   logic                 timer_clr;
   logic                 bit_end;
   logic                 accept;
   logic                 start_frame;

   // Bit-period timer; held at zero while idle so a frame starts at count 0.
   uart_bit_timer #(
      .FREQUENCY (FREQUENCY)
   ) u_bit_timer (
      .clk     (clk),
      .i_Rst_n (i_Rst_n),
      .clr_i   (timer_clr),
      .tc_c_o  (bit_end)
   );

   assign accept = i_DV && !hold_q.full;

   // Next-state and output logic.
   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      shift_d     = shift_q;
      idx_d       = idx_q;
      line_d      = line_q;
      active_d    = active_q;
      done_d      = 1'b0;
      timer_clr   = 1'b0;
      start_frame = 1'b0;

      case (state_q)
         IDLE: begin
            line_d    = 1'b1;
            active_d  = 1'b0;
            timer_clr = 1'b1;
            if (hold_q.full) begin
               start_frame = 1'b1;
            end
         end

         START: begin
            if (bit_end) begin
               line_d  = shift_q[0];
               shift_d = shift_q >> 1;
               state_d = DATA;
            end
         end

         DATA: begin
            if (bit_end) begin
               if (idx_q != LAST_DATA) begin
                  idx_d   = idx_q + IDX_W'(1);
                  line_d  = shift_q[0];
                  shift_d = shift_q >> 1;
               end else begin
                  idx_d   = '0;
                  line_d  = 1'b1;
                  state_d = STOP;
               end
            end
         end

         STOP: begin
            if (bit_end) begin
               if (idx_q != LAST_STOP) begin
                  idx_d = idx_q + IDX_W'(1);
               end else begin
                  done_d = 1'b1;
                  if (hold_q.full) begin
                     start_frame = 1'b1;
                  end else begin
                     active_d = 1'b0;
                     state_d  = IDLE;
                  end
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Move the held byte into the shifter and begin the start bit.
      if (start_frame) begin
         shift_d     = hold_q.data;
         hold_d.full = 1'b0;
         idx_d       = '0;
         line_d      = 1'b0;
         active_d    = 1'b1;
         state_d     = START;
      end

      // Cannot coincide with start_frame: accept needs an empty holding register.
      if (accept) begin
         hold_d.full = 1'b1;
         hold_d.data = i_Byte;
      end
   end

   always_ff @(posedge clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q  <= IDLE;
         hold_q   <= '0;
         shift_q  <= '0;
         idx_q    <= '0;
         line_q   <= 1'b1;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         shift_q  <= shift_d;
         idx_q    <= idx_d;
         line_q   <= line_d;
         active_q <= active_d;
         done_q   <= done_d;
      end
   end

   assign o_Serial_Data = line_q;
   assign o_Ready       = ~hold_q.full;
   assign o_Active      = active_q;
   assign o_Done        = done_q;

endmodule : uart_transmitter

// File: tb/tb_uart_transmitter.sv
// ----------------------------------------------------------------------------
// tb_uart_transmitter
// Self-checking bench: two transmitters (87 and 2 clocks per bit) checked
// every cycle against a frame-level reference model, plus a line decoder
// whose recovered bytes are compared with the bytes the model says were sent.
// ----------------------------------------------------------------------------
module tb_uart_transmitter;

   localparam int unsigned F_A = 87;
   localparam int unsigned F_B = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       dv_a, dv_b;
   logic [7:0] byte_in;
   logic       line_a, ready_a, active_a, done_a;
   logic       line_b, ready_b, active_b, done_b;

   always #5 clk = ~clk;

   uart_transmitter #(.FREQUENCY(F_A)) u_dut_a (
      .clk           (clk),
      .i_Rst_n       (rst_n),
      .i_DV          (dv_a),
      .i_Byte        (byte_in),
      .o_Serial_Data (line_a),
      .o_Ready       (ready_a),
      .o_Active      (active_a),
      .o_Done        (done_a)
   );

   uart_transmitter #(.FREQUENCY(F_B)) u_dut_b (
      .clk           (clk),
      .i_Rst_n       (rst_n),
      .i_DV          (dv_b),
      .i_Byte        (byte_in),
      .o_Serial_Data (line_b),
      .o_Ready       (ready_b),
      .o_Active      (active_b),
      .o_Done        (done_b)
   );

   int         sel;
   int         cur_f;
   logic [3:0] outs_m;  // {line, active, ready, done} of the selected DUT
   logic       line_m, done_m;

   always_comb begin
      if (sel == 0) outs_m = {line_a, active_a, ready_a, done_a};
      else          outs_m = {line_b, active_b, ready_b, done_b};
   end
   assign line_m = outs_m[3];
   assign done_m = outs_m[0];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   // ---------------- reference model (frame level) ----------------
   bit         m_hold_full;
   logic [7:0] m_hold_byte;
   bit         m_busy;
   int         m_pos;    // clocks since the start-bit edge of the current frame
   logic [7:0] m_byte;
   bit         m_done;
   logic [7:0] exp_q[$];
   logic [7:0] rx_q[$];
   int         done_q[$];
   int         cyc = 0;

   task automatic model_reset();
      m_hold_full = 0; m_hold_byte = '0; m_busy = 0; m_pos = 0;
      m_byte = '0; m_done = 0; exp_q.delete();
   endtask

   task automatic model_edge(input bit dv, input logic [7:0] b);
      bit acc;
      acc    = dv && !m_hold_full;
      m_done = 0;
      if (m_busy) begin
         m_pos++;
         if (m_pos == 10 * cur_f) begin
            m_done = 1;
            exp_q.push_back(m_byte);
            if (m_hold_full) begin
               m_byte = m_hold_byte; m_pos = 0; m_hold_full = 0;
            end else begin
               m_busy = 0;
            end
         end
      end else if (m_hold_full) begin
         m_busy = 1; m_pos = 0; m_byte = m_hold_byte; m_hold_full = 0;
      end
      if (acc) begin
         m_hold_full = 1; m_hold_byte = b;
      end
   endtask

   // Bit slot 0 is start, 1..8 data LSB first, 9 stop.
   function automatic logic exp_line();
      int k;
      if (!m_busy) return 1'b1;
      k = m_pos / cur_f;
      if (k == 0) return 1'b0;
      if (k <= 8) return m_byte[k-1];
      return 1'b1;
   endfunction

   // One clock: drive at negedge, advance model at posedge, compare after.
   task automatic cycle(input bit dv, input logic [7:0] b);
      logic [3:0] exp;
      @(negedge clk);
      dv_a = (sel == 0) && dv;
      dv_b = (sel == 1) && dv;
      byte_in = b;
      @(posedge clk);
      cyc++;
      if (rst_n) model_edge(dv, b);
      #1;
      exp = {exp_line(), m_busy, ~m_hold_full, m_done};
      check_eq("outs{line,active,ready,done}", 32'(outs_m), 32'(exp));
      if (done_m) done_q.push_back(cyc);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
   endtask

   task automatic compare_rx(input string tag);
      check_eq({tag, "_rx_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
         check_eq({tag, "_rx_byte"}, 32'(rx_q[i]), 32'(exp_q[i]));
      rx_q.delete();
      exp_q.delete();
   endtask

   // ---------------- line decoder (loopback receiver) ----------------
   bit         mon_busy = 0;
   int         mon_cnt  = 0;
   logic [7:0] mon_byte = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         mon_busy = 0;
         mon_cnt  = 0;
         rx_q.delete();
      end else if (!mon_busy) begin
         if (line_m == 1'b0) begin
            mon_busy = 1;
            mon_cnt  = 0;
         end
      end else begin
         mon_cnt++;
         for (int k = 1; k <= 8; k++)
            if (mon_cnt == k * cur_f + cur_f / 2) mon_byte[k-1] = line_m;
         if (mon_cnt == 9 * cur_f + cur_f / 2) begin
            rx_q.push_back(mon_byte);
            mon_busy = 0;
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int  acc_cyc;
      bit  hit;

      rst_n = 1'b0; dv_a = 1'b0; dv_b = 1'b0; byte_in = '0;
      sel = 0; cur_f = F_A;
      model_reset();

      repeat (3) @(posedge clk);
      #1 check_eq("reset_outs_a", 32'(outs_m), 32'(4'b1010));
      sel = 1;
      #1 check_eq("reset_outs_b", 32'(outs_m), 32'(4'b1010));
      sel = 0;
      @(negedge clk) rst_n = 1'b1;

      // Single frame 0xA5.
      done_q.delete();
      cycle(1'b1, 8'hA5);
      acc_cyc = cyc;
      idle(1000);
      check_eq("a5_done_count", 32'(done_q.size()), 32'd1);
      if (done_q.size() >= 1) check_eq("a5_done_latency", 32'(done_q[0] - acc_cyc), 32'd871);
      compare_rx("a5");

      // Back-to-back 0x00 / 0xFF, with 0x55 offered while full.
      done_q.delete();
      cycle(1'b1, 8'h00);
      idle(100);
      cycle(1'b1, 8'hFF);
      cycle(1'b1, 8'h55);
      idle(1900);
      check_eq("b2b_done_count", 32'(done_q.size()), 32'd2);
      if (done_q.size() >= 2) check_eq("b2b_done_spacing", 32'(done_q[1] - done_q[0]), 32'd870);
      compare_rx("b2b");

      // Random sparse traffic.
      for (int i = 0; i < 6000; i++)
         cycle($urandom_range(0, 299) == 0, 8'($urandom));
      idle(1000);
      compare_rx("rand_a");

      // Reset during data bit 3 with a byte held.
      cycle(1'b1, 8'h96);
      cycle(1'b0, 8'h00);
      cycle(1'b1, 8'h3C);
      hit = 0;
      for (int i = 0; i < 2000 && !hit; i++) begin
         cycle(1'b0, 8'h00);
         if (m_busy && m_pos == 4 * cur_f + 10) hit = 1;
      end
      check_eq("reach_data_bit3", 32'(hit), 32'd1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_eq("midframe_reset_outs", 32'(outs_m), 32'(4'b1010));
      model_reset();
      repeat (3) cycle(1'b0, 8'h00);
      @(negedge clk) rst_n = 1'b1;
      idle(300);
      compare_rx("after_reset");

      // Loopback of 0x3C and 0x81.
      cycle(1'b1, 8'h3C);
      idle(50);
      cycle(1'b1, 8'h81);
      idle(2000);
      compare_rx("loopback");

      // Two clocks per bit.
      sel = 1;
      cur_f = F_B;
      done_q.delete();
      cycle(1'b1, 8'h01);
      acc_cyc = cyc;
      idle(30);
      check_eq("f2_done_count", 32'(done_q.size()), 32'd1);
      if (done_q.size() >= 1) check_eq("f2_done_latency", 32'(done_q[0] - acc_cyc), 32'd21);
      compare_rx("f2");

      // Dense random traffic at two clocks per bit.
      for (int i = 0; i < 3000; i++)
         cycle(1'($urandom_range(0, 1)), 8'($urandom));
      idle(100);
      compare_rx("rand_b");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_uart_transmitter
